// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register
// Single outstanding imem request; FETCH/WAIT/HOLD controller with flush-drop tracking.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [31:0] r_buf;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_drop_nxt;
  logic [31:0] w_buf_nxt;
  logic        w_ifid_valid_nxt;
  logic [31:0] w_ifid_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic        w_hs;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;

  assign imem_req_valid = (r_state == S_FETCH) && !reset;
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  assign ifid_valid     = r_ifid_valid;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_instr     = r_ifid_instr;
  assign ifid_pc_plus4  = r_ifid_pc + 32'd4;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_nxt       = r_drop;
    w_buf_nxt        = r_buf;
    w_deliver        = 1'b0;
    w_deliver_instr  = imem_rsp_data;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;

    case (r_state)
      S_FETCH: begin
        if (w_hs) begin
          w_state_nxt = S_WAIT;
          w_drop_nxt  = flush;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A response arriving with the flush is the victim itself; otherwise drop the later one.
          w_state_nxt = imem_rsp_valid ? S_FETCH : S_WAIT;
          w_drop_nxt  = !imem_rsp_valid;
        end else if (imem_rsp_valid) begin
          w_state_nxt = S_FETCH;
          w_drop_nxt  = 1'b0;
          if (!r_drop) begin
            if (stall_IFID) begin
              w_buf_nxt   = imem_rsp_data;
              w_state_nxt = S_HOLD;
            end else begin
              w_deliver = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        w_deliver_instr = r_buf;
        if (flush) begin
          w_state_nxt = S_FETCH;
        end else if (!stall_IFID) begin
          w_deliver   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_drop_nxt  = 1'b0;
      end
    endcase

    if (flush) begin
      w_pc_nxt         = branch_target & 32'hFFFF_FFFC;
      w_ifid_valid_nxt = 1'b0;
      w_ifid_pc_nxt    = 32'd0;
      w_ifid_instr_nxt = NOP_INSTR;
    end else if (!stall_IFID) begin
      if (w_deliver) begin
        w_pc_nxt         = r_pc + 32'd4;
        w_ifid_valid_nxt = 1'b1;
        w_ifid_pc_nxt    = r_pc;
        w_ifid_instr_nxt = w_deliver_instr;
      end else begin
        w_ifid_valid_nxt = 1'b0;
        w_ifid_pc_nxt    = 32'd0;
        w_ifid_instr_nxt = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_buf        <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_buf        <= w_buf_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven directed bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_IFID;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_IFID     (stall_IFID),
    .flush          (flush),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
  endtask

  task automatic add(input logic st, input logic fl, input logic [31:0] tgt, input logic rdy,
                     input logic rv, input logic [31:0] rdata, input logic e_rv,
                     input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_p4);
    vec_t v;
    v.st = st; v.fl = fl; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_p4 = e_p4;
    vecs.push_back(v);
  endtask

  task automatic bubble_add(input logic st, input logic fl, input logic [31:0] tgt, input logic rdy,
                            input logic rv, input logic [31:0] rdata, input logic e_rv,
                            input logic [31:0] e_addr);
    add(st, fl, tgt, rdy, rv, rdata, e_rv, e_addr, 1'b0, 32'd0, NOP, 32'd4);
  endtask

  task automatic check_ifid(input string tag, input int row, input logic iv, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] p4);
    chk({tag, "_ifid_valid"}, row, {31'd0, ifid_valid}, {31'd0, iv});
    chk({tag, "_ifid_pc"}, row, ifid_pc, pc);
    chk({tag, "_ifid_instr"}, row, ifid_instr, instr);
    chk({tag, "_ifid_pc_plus4"}, row, ifid_pc_plus4, p4);
  endtask

  initial begin
    reset = 1'b1; stall_IFID = 1'b0; flush = 1'b0; branch_target = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

    // Rows: st fl tgt rdy rv rdata | e_rv e_addr | IF/ID after the edge
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'h0);
    add(0, 0, 0, 1, 1, 32'h00500093, 0, 32'h0, 1, 32'h0, 32'h00500093, 32'h4);
    add(1, 0, 0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 32'h00500093, 32'h4);
    add(1, 0, 0, 0, 1, 32'h00A00113, 0, 32'h4, 1, 32'h0, 32'h00500093, 32'h4);
    add(1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h0, 32'h00500093, 32'h4);
    add(1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h0, 32'h00500093, 32'h4);
    add(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h4, 32'h00A00113, 32'h8);
    for (int i = 0; i < 4; i++) bubble_add(0, 0, 0, 0, 0, 0, 1, 32'h8);
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'h8);
    bubble_add(0, 1, 32'h103, 0, 0, 0, 0, 32'h8);
    bubble_add(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h100);
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'h100);
    add(0, 0, 0, 0, 1, 32'h00308193, 0, 32'h100, 1, 32'h100, 32'h00308193, 32'h104);
    bubble_add(1, 1, 32'h200, 1, 0, 0, 1, 32'h104);
    bubble_add(0, 0, 0, 0, 1, 32'h11111111, 0, 32'h200);
    bubble_add(0, 1, 32'hFFFFFFFE, 0, 0, 0, 1, 32'h200);
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFC);
    add(0, 0, 0, 0, 1, 32'h00000073, 0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h00000073, 32'h0);
    bubble_add(0, 0, 0, 0, 0, 0, 1, 32'h0);
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'h0);
    bubble_add(1, 0, 0, 0, 1, 32'h22222222, 0, 32'h0);
    bubble_add(0, 1, 32'h40, 0, 0, 0, 0, 32'h0);
    bubble_add(0, 0, 0, 1, 0, 0, 1, 32'h40);
    add(0, 0, 0, 0, 1, 32'h33333333, 0, 32'h40, 1, 32'h40, 32'h33333333, 32'h44);

    // Reset state and request suppression while reset is held
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_req_valid", -1, {31'd0, imem_req_valid}, 32'd0);
    check_ifid("reset", -1, 1'b0, 32'd0, NOP, 32'd4);
    reset = 1'b0;

    foreach (vecs[i]) begin
      stall_IFID = vecs[i].st; flush = vecs[i].fl; branch_target = vecs[i].tgt;
      imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rv; imem_rsp_data = vecs[i].rdata;
      #1;
      chk("req_valid", i, {31'd0, imem_req_valid}, {31'd0, vecs[i].e_rv});
      chk("req_addr", i, imem_req_addr, vecs[i].e_addr);
      @(posedge clk); #1;
      check_ifid("vec", i, vecs[i].e_iv, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4);
    end

    // Reset while a request is in flight: back to RESET_PC, request reissued after release
    stall_IFID = 1'b0; flush = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("pre_rst_req_addr", 100, imem_req_addr, 32'h44);
    @(posedge clk); #1;
    chk("wait_req_valid", 101, {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b1; imem_req_ready = 1'b0; flush = 1'b1; branch_target = 32'h500;
    #1;
    chk("rst_cycle_req_valid", 102, {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    check_ifid("rst_mid", 103, 1'b0, 32'd0, NOP, 32'd4);
    reset = 1'b0; flush = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("post_rst_req_valid", 104, {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", 104, imem_req_addr, 32'h0);
    @(posedge clk); #1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100093;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    check_ifid("post_rst_fetch", 105, 1'b1, 32'h0, 32'h00100093, 32'h4);
    #1;
    chk("post_rst_next_addr", 106, imem_req_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
